// File: rtl/ex_mem_pipe_reg_if.sv
// rtl/ex_mem_pipe_reg_if.sv - Execute->Memory handshake and data bundle; forwarding signals exist only with EX_MEM_FWD_EN
interface ex_mem_pipe_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 5,
    parameter int REG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [DATA_WIDTH-1:0] ALU_RESULT_IN;
    logic [DATA_WIDTH-1:0] READ_DATA_2_IN;
    logic [CTRL_WIDTH-1:0] CONTROL_IN;
    logic                  ZERO_IN;
    logic [REG_WIDTH-1:0]  WRITE_REGISTER_IN;
    logic                  HIT_IN;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [DATA_WIDTH-1:0] ALU_RESULT;
    logic [DATA_WIDTH-1:0] READ_DATA_2;
    logic [CTRL_WIDTH-1:0] CONTROL;
    logic                  ZERO;
    logic [REG_WIDTH-1:0]  WRITE_REGISTER;
    logic                  HIT;
    logic                  FLUSH;
    logic [CNT_WIDTH-1:0]  STALL_CNT;
`ifdef EX_MEM_FWD_EN
    logic                  FWD_VALID;
    logic [REG_WIDTH-1:0]  FWD_REG;
    logic [DATA_WIDTH-1:0] FWD_DATA;
`endif

    modport slave (
`ifdef EX_MEM_FWD_EN
        output FWD_VALID, FWD_REG, FWD_DATA,
`endif
        input  IN_VALID, ALU_RESULT_IN, READ_DATA_2_IN, CONTROL_IN, ZERO_IN,
               WRITE_REGISTER_IN, HIT_IN, OUT_READY, FLUSH,
        output IN_READY, OUT_VALID, ALU_RESULT, READ_DATA_2, CONTROL, ZERO,
               WRITE_REGISTER, HIT, STALL_CNT
    );

    modport master (
`ifdef EX_MEM_FWD_EN
        input  FWD_VALID, FWD_REG, FWD_DATA,
`endif
        output IN_VALID, ALU_RESULT_IN, READ_DATA_2_IN, CONTROL_IN, ZERO_IN,
               WRITE_REGISTER_IN, HIT_IN, OUT_READY, FLUSH,
        input  IN_READY, OUT_VALID, ALU_RESULT, READ_DATA_2, CONTROL, ZERO,
               WRITE_REGISTER, HIT, STALL_CNT
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM pipeline register with 2-entry skid buffer, flush and stall counter; EX_MEM_FWD_EN adds forwarding outputs
module ex_mem_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 5,
    parameter int REG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst,
    ex_mem_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] rd2;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  zero;
        logic [REG_WIDTH-1:0]  wreg;
        logic                  hit;
    } beat_t;

    // Occupancy: main entry drives the outputs, skid entry holds the beat that arrived under back-pressure
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_MAIN  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state;
    beat_t                main_q;
    beat_t                skid_q;
    beat_t                in_beat;
    logic                 main_valid;
    logic                 accept;
    logic                 pop;
    logic [CNT_WIDTH-1:0] stall_q;

    assign in_beat = '{alu:  bus.ALU_RESULT_IN,  rd2:  bus.READ_DATA_2_IN,
                       ctrl: bus.CONTROL_IN,     zero: bus.ZERO_IN,
                       wreg: bus.WRITE_REGISTER_IN, hit: bus.HIT_IN};

    assign main_valid = (state != S_EMPTY);
    assign accept     = bus.IN_VALID && (state != S_FULL);
    assign pop        = main_valid && bus.OUT_READY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (bus.FLUSH) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (accept) begin
                    main_q <= in_beat;
                    state  <= S_MAIN;
                end
                S_MAIN: begin
                    if (accept && pop) begin
                        main_q <= in_beat;
                    end else if (accept) begin
                        skid_q <= in_beat;
                        state  <= S_FULL;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_FULL: if (pop) begin
                    main_q <= skid_q;
                    state  <= S_MAIN;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_valid && !bus.OUT_READY && stall_q != CNT_MAX) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.IN_READY       = (state != S_FULL);
    assign bus.OUT_VALID      = main_valid;
    assign bus.ALU_RESULT     = main_q.alu;
    assign bus.READ_DATA_2    = main_q.rd2;
    // Gating CONTROL keeps an idle slot from issuing a memory access or branch downstream
    assign bus.CONTROL        = main_valid ? main_q.ctrl : '0;
    assign bus.ZERO           = main_q.zero;
    assign bus.WRITE_REGISTER = main_q.wreg;
    assign bus.HIT            = main_q.hit;
    assign bus.STALL_CNT      = stall_q;

`ifdef EX_MEM_FWD_EN
    beat_t young;

    assign young         = (state == S_FULL) ? skid_q : main_q;
    assign bus.FWD_VALID = main_valid && (young.ctrl[4:3] != 2'b00) && (young.wreg != '0);
    assign bus.FWD_REG   = main_valid ? young.wreg : '0;
    assign bus.FWD_DATA  = main_valid ? young.alu : '0;
`endif
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - bench for ex_mem_pipe_reg: vector table, directed corners, random vs queue model
module tb_ex_mem_pipe_reg;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg_if bus();
    ex_mem_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  ctrl;
        logic        zero;
        logic [4:0]  wreg;
        logic        hit;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [31:0] a;
        logic        orr;
        logic        fl;
        logic        eov;
        logic [31:0] ea;
        logic        eir;
        logic [15:0] es;
    } vec_t;

    beat_t       q[$];
    int unsigned m_stall;
    vec_t        tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a FIFO of at most two beats; the head is what Memory sees
    task automatic step();
        beat_t b;
        bit acc, pp;
        b.alu  = bus.ALU_RESULT_IN;
        b.rd2  = bus.READ_DATA_2_IN;
        b.ctrl = bus.CONTROL_IN;
        b.zero = bus.ZERO_IN;
        b.wreg = bus.WRITE_REGISTER_IN;
        b.hit  = bus.HIT_IN;
        acc = bus.IN_VALID && (q.size() < 2);
        pp  = (q.size() > 0) && bus.OUT_READY;
        if (q.size() > 0 && !bus.OUT_READY && m_stall < 65535) m_stall++;
        if (bus.FLUSH) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.OUT_VALID), 64'(q.size() > 0));
        chk({tag, "_in_ready"},  64'(bus.IN_READY),  64'(q.size() < 2));
        chk({tag, "_stall"},     64'(bus.STALL_CNT), 64'(m_stall));
        if (q.size() > 0) begin
            chk({tag, "_alu"},  64'(bus.ALU_RESULT),     64'(q[0].alu));
            chk({tag, "_rd2"},  64'(bus.READ_DATA_2),    64'(q[0].rd2));
            chk({tag, "_ctrl"}, 64'(bus.CONTROL),        64'(q[0].ctrl));
            chk({tag, "_misc"}, 64'({bus.ZERO, bus.HIT, bus.WRITE_REGISTER}),
                                64'({q[0].zero, q[0].hit, q[0].wreg}));
        end else begin
            chk({tag, "_ctrl_idle"}, 64'(bus.CONTROL), 64'(0));
        end
`ifdef EX_MEM_FWD_EN
        if (q.size() > 0) begin
            chk({tag, "_fwd_valid"}, 64'(bus.FWD_VALID),
                64'(q[$].ctrl[4:3] != 2'b00 && q[$].wreg != 5'd0));
            chk({tag, "_fwd_reg"},  64'(bus.FWD_REG),  64'(q[$].wreg));
            chk({tag, "_fwd_data"}, 64'(bus.FWD_DATA), 64'(q[$].alu));
        end else begin
            chk({tag, "_fwd_idle"}, 64'({bus.FWD_VALID, bus.FWD_REG, bus.FWD_DATA}), 64'(0));
        end
`endif
    endtask

    task automatic drive(input logic iv, input logic [31:0] a, input logic [4:0] c,
                         input logic [4:0] r, input logic orr, input logic fl);
        bus.IN_VALID          = iv;
        bus.ALU_RESULT_IN     = a;
        bus.READ_DATA_2_IN    = ~a;
        bus.CONTROL_IN        = c;
        bus.ZERO_IN           = a[0];
        bus.WRITE_REGISTER_IN = r;
        bus.HIT_IN            = a[1];
        bus.OUT_READY         = orr;
        bus.FLUSH             = fl;
    endtask

    task automatic do_reset();
        drive(1'b1, 32'hDEAD, 5'h1F, 5'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_stall = 0;
        drive(1'b0, 32'h0, 5'h0, 5'd0, 1'b1, 1'b0);
    endtask

    function automatic vec_t v(input logic iv, input logic [31:0] a, input logic orr, input logic fl,
                               input logic eov, input logic [31:0] ea, input logic eir, input logic [15:0] es);
        vec_t t;
        t.iv = iv; t.a = a; t.orr = orr; t.fl = fl;
        t.eov = eov; t.ea = ea; t.eir = eir; t.es = es;
        return t;
    endfunction

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'h0, 5'd0, 1'b1, 1'b0);

        // streaming, back-pressure with skid, flush from FULL and from MAIN
        tbl[0]  = v(1, 32'h1,  1, 0, 1, 32'h1,  1, 0);
        tbl[1]  = v(1, 32'h2,  1, 0, 1, 32'h2,  1, 0);
        tbl[2]  = v(1, 32'h3,  1, 0, 1, 32'h3,  1, 0);
        tbl[3]  = v(1, 32'h4,  1, 0, 1, 32'h4,  1, 0);
        tbl[4]  = v(0, 32'h0,  1, 0, 0, 32'h0,  1, 0);
        tbl[5]  = v(1, 32'hA,  0, 0, 1, 32'hA,  1, 0);
        tbl[6]  = v(1, 32'hB,  0, 0, 1, 32'hA,  0, 1);
        tbl[7]  = v(1, 32'hC,  0, 0, 1, 32'hA,  0, 2);
        tbl[8]  = v(0, 32'h0,  1, 0, 1, 32'hB,  1, 2);
        tbl[9]  = v(0, 32'h0,  1, 0, 0, 32'h0,  1, 2);
        tbl[10] = v(1, 32'h11, 0, 0, 1, 32'h11, 1, 2);
        tbl[11] = v(1, 32'h12, 0, 0, 1, 32'h11, 0, 3);
        tbl[12] = v(1, 32'h13, 0, 1, 0, 32'h0,  1, 4);
        tbl[13] = v(0, 32'h0,  1, 0, 0, 32'h0,  1, 4);
        tbl[14] = v(1, 32'h14, 1, 0, 1, 32'h14, 1, 4);
        tbl[15] = v(1, 32'h15, 1, 0, 1, 32'h15, 1, 4);
        tbl[16] = v(1, 32'h16, 1, 1, 0, 32'h0,  1, 4);
        tbl[17] = v(0, 32'h0,  1, 0, 0, 32'h0,  1, 4);

        do_reset();
        chk("reset_out_valid", 64'(bus.OUT_VALID),  64'(0));
        chk("reset_in_ready",  64'(bus.IN_READY),   64'(1));
        chk("reset_control",   64'(bus.CONTROL),    64'(0));
        chk("reset_stall",     64'(bus.STALL_CNT),  64'(0));
        chk("reset_alu",       64'(bus.ALU_RESULT), 64'(0));

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].a, 5'h0A, 5'd9, tbl[i].orr, tbl[i].fl);
            step();
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.OUT_VALID), 64'(tbl[i].eov));
            chk($sformatf("vec%0d_in_ready", i),  64'(bus.IN_READY),  64'(tbl[i].eir));
            chk($sformatf("vec%0d_control", i),   64'(bus.CONTROL),   64'(tbl[i].eov ? 5'h0A : 5'h00));
            chk($sformatf("vec%0d_stall", i),     64'(bus.STALL_CNT), 64'(tbl[i].es));
            if (tbl[i].eov)
                chk($sformatf("vec%0d_alu", i), 64'(bus.ALU_RESULT), 64'(tbl[i].a == 32'h0 ? tbl[i].ea : tbl[i].ea));
        end

        // saturation: one parked beat, Memory never ready
        do_reset();
        drive(1'b1, 32'h77, 5'h0A, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 5'h0, 5'd0, 1'b0, 1'b0);
        repeat (65540) step();
        chk("sat_stall", 64'(bus.STALL_CNT), 64'(16'hFFFF));
        step();
        chk("sat_no_wrap", 64'(bus.STALL_CNT), 64'(16'hFFFF));
        chk("sat_hold_alu", 64'(bus.ALU_RESULT), 64'(32'h77));
        bus.FLUSH = 1'b1;
        step();
        bus.FLUSH = 1'b0;
        chk("sat_flush_keeps_cnt", 64'(bus.STALL_CNT), 64'(16'hFFFF));

`ifdef EX_MEM_FWD_EN
        do_reset();
        drive(1'b1, 32'h55, 5'b10000, 5'd7, 1'b0, 1'b0);
        step();
        chk("fwd_valid", 64'(bus.FWD_VALID), 64'(1));
        chk("fwd_reg",   64'(bus.FWD_REG),   64'(7));
        chk("fwd_data",  64'(bus.FWD_DATA),  64'(32'h55));
        drive(1'b1, 32'h55, 5'b10000, 5'd0, 1'b0, 1'b0);
        step();
        chk("fwd_reg0_valid", 64'(bus.FWD_VALID), 64'(0));
        drive(1'b0, 32'h0, 5'h0, 5'd0, 1'b0, 1'b1);
        step();
        chk("fwd_flush", 64'({bus.FWD_VALID, bus.FWD_REG, bus.FWD_DATA}), 64'(0));
        bus.FLUSH = 1'b0;
`endif

        // random traffic against the queue model
        do_reset();
        check_model("rnd_init");
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, $urandom, 5'($urandom), 5'($urandom % 8),
                  ($urandom % 5) < 3, ($urandom % 20) == 0);
            step();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
